fetch_stage: RTL and testbench

Instruction-fetch stage of the DLX pipeline, directly upstream of the decode stage. It holds the fetch PC and issues word reads to instruction memory over a request/response handshake that tolerates variable latency. Responses are buffered in a 2-entry queue that feeds the decoder's instruction and PC inputs. Redirects come from decode (jump) and from execute (taken branch), and trigger a flush plus discard of in-flight reads.

---
 rtl/fetch_stage_if.sv | 35 +++
 rtl/fetch_stage.sv | 115 +++++++++++
 tb/tb_fetch_stage.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Fetch-stage handshake bundle: instruction-memory request/response
//               port plus the decode-facing instruction, PC and redirect signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        stall_ID;
    logic        Pc_cmd_id;
    logic [31:0] pc_in_ID;
    logic        pc_cmd_ex;
    logic [31:0] pc_in_EX;
    logic [31:0] i_data_read;
    logic [31:0] PC_ID;
    logic        valid_ID;

    modport master (
        output i_req, i_addr, i_data_read, PC_ID, valid_ID,
        input  i_ready, i_rvalid, i_rdata, stall_ID,
               Pc_cmd_id, pc_in_ID, pc_cmd_ex, pc_in_EX
    );

    modport slave (
        input  i_req, i_addr, i_data_read, PC_ID, valid_ID,
        output i_ready, i_rvalid, i_rdata, stall_ID,
               Pc_cmd_id, pc_in_ID, pc_cmd_ex, pc_in_EX
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : DLX instruction fetch with credit-limited variable-latency reads,
//               a 2-entry response FIFO toward decode, and jump/branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  wire logic     clk,
    input  wire logic     reset,
    fetch_stage_if.master bus
);

    logic [31:0] r_fetch_pc;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_drop;
    logic [1:0]  r_count;
    logic [31:0] r_fifo_instr [2];
    logic [31:0] r_fifo_addr  [2];
    logic [31:0] r_aq_addr    [2];
    logic        r_aq_wr;
    logic        r_aq_rd;

    logic        w_valid;
    logic        w_pop;
    logic        w_redirect;
    logic [31:0] w_target;
    logic [2:0]  w_inflight;
    logic        w_credit;
    logic        w_accept;
    logic        w_resp;
    logic        w_push;
    logic [31:0] w_push_addr;

    assign w_valid    = (r_count != 2'd0);
    assign w_pop      = w_valid && !bus.stall_ID;
    assign w_redirect = bus.pc_cmd_ex || (bus.Pc_cmd_id && !bus.stall_ID);
    assign w_target   = bus.pc_cmd_ex ? (bus.pc_in_EX & ~32'h3) : (bus.pc_in_ID & ~32'h3);

    // Every accepted read owns a FIFO slot, so a pop in this cycle frees one.
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_credit   = (w_inflight < 3'd2) || w_pop;

    assign bus.i_req  = !reset && !w_redirect && w_credit;
    assign bus.i_addr = r_fetch_pc;

    assign w_accept    = bus.i_req && bus.i_ready;
    assign w_resp      = bus.i_rvalid && (r_outstanding != 2'd0);
    assign w_push      = w_resp && (r_drop == 2'd0) && !w_redirect;
    assign w_push_addr = r_aq_addr[r_aq_rd];

    assign bus.valid_ID    = w_valid;
    assign bus.i_data_read = w_valid ? r_fifo_instr[0] : NOP_INSN;
    assign bus.PC_ID       = w_valid ? (r_fifo_addr[0] + 32'd4) : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= 2'd0;
            r_drop        <= 2'd0;
            r_count       <= 2'd0;
            r_aq_wr       <= 1'b0;
            r_aq_rd       <= 1'b0;
        end else begin
            // The address queue stays aligned with memory even for dropped reads.
            if (w_accept) begin
                r_aq_addr[r_aq_wr] <= r_fetch_pc;
                r_aq_wr            <= ~r_aq_wr;
            end
            if (w_resp) begin
                r_aq_rd <= ~r_aq_rd;
            end
            r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, w_resp};

            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_drop     <= r_outstanding - {1'b0, w_resp};
                r_count    <= 2'd0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_resp && (r_drop != 2'd0)) begin
                    r_drop <= r_drop - 2'd1;
                end
                case ({w_push, w_pop})
                    2'b10: begin
                        r_fifo_instr[r_count[0]] <= bus.i_rdata;
                        r_fifo_addr[r_count[0]]  <= w_push_addr;
                        r_count                  <= r_count + 2'd1;
                    end
                    2'b01: begin
                        r_fifo_instr[0] <= r_fifo_instr[1];
                        r_fifo_addr[0]  <= r_fifo_addr[1];
                        r_count         <= r_count - 2'd1;
                    end
                    2'b11: begin
                        // With one entry the new word lands directly at the head.
                        r_fifo_instr[0] <= (r_count == 2'd2) ? r_fifo_instr[1] : bus.i_rdata;
                        r_fifo_addr[0]  <= (r_count == 2'd2) ? r_fifo_addr[1]  : w_push_addr;
                        r_fifo_instr[1] <= bus.i_rdata;
                        r_fifo_addr[1]  <= w_push_addr;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Randomised scoreboard bench for fetch_stage with a program-order
//               reference stream and a variable-latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (C_RESET_PC),
        .NOP_INSN (C_NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int consumed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    ready_mode = 0;
    int    lat_min    = 1;
    int    lat_max    = 1;

    initial begin
        bus.i_ready  = 1'b0;
        bus.i_rvalid = 1'b0;
        bus.i_rdata  = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = ($urandom_range(0, 3) != 0);
                default: bus.i_ready = ((cyc % 5) >= 3);
            endcase
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.i_rvalid = 1'b1;
                bus.i_rdata  = mem_word(mq[0].addr);
            end else begin
                bus.i_rvalid = 1'b0;
                bus.i_rdata  = $urandom;
            end
        end
    end

    initial begin
        mreq_t m;
        forever begin
            @(negedge clk);
            if (reset) begin
                mq.delete();
            end else begin
                if (bus.i_rvalid && mq.size() > 0) void'(mq.pop_front());
                if (bus.i_req && bus.i_ready) begin
                    m.addr = bus.i_addr;
                    m.due  = cyc + $urandom_range(lat_min, lat_max);
                    mq.push_back(m);
                    check("outstanding_le_2", {31'd0, (mq.size() <= 2)}, 32'd1);
                    check("addr_aligned", {30'd0, bus.i_addr[1:0]}, 32'd0);
                end
            end
        end
    end

    // ---------------- scoreboard: expected program-order stream ----------------
    logic [31:0] exp_q[$];

    initial begin
        logic [31:0] ea;
        exp_q.push_back(C_RESET_PC);
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                exp_q.push_back(C_RESET_PC);
            end else begin
                if (!bus.valid_ID) begin
                    check("idle_insn", bus.i_data_read, C_NOP);
                    check("idle_pc", bus.PC_ID, 32'd0);
                end else if (!bus.stall_ID) begin
                    ea = exp_q.pop_front();
                    check("insn", bus.i_data_read, mem_word(ea));
                    check("pc_id", bus.PC_ID, ea + 32'd4);
                    consumed++;
                    exp_q.push_back(ea + 32'd4);
                end
                if (bus.pc_cmd_ex) begin
                    exp_q.delete();
                    exp_q.push_back(bus.pc_in_EX & ~32'h3);
                end else if (bus.Pc_cmd_id && !bus.stall_ID) begin
                    exp_q.delete();
                    exp_q.push_back(bus.pc_in_ID & ~32'h3);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_cmds();
        bus.Pc_cmd_id = 1'b0;
        bus.pc_cmd_ex = 1'b0;
        bus.pc_in_ID  = 32'd0;
        bus.pc_in_EX  = 32'd0;
    endtask

    // Returns positioned in the first cycle after reset release (posedge + 1).
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        clear_cmds();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 60 && !bus.valid_ID; k++) @(negedge clk);
        check(name, {31'd0, bus.valid_ID}, 32'd1);
    endtask

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF4 | 32'($urandom_range(0, 3));
        return $urandom;
    endfunction

    initial begin
        int          c0;
        logic [31:0] d_hold;
        logic [31:0] p_hold;
        bus.stall_ID = 1'b0;
        clear_cmds();
        reset = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_i_req", {31'd0, bus.i_req}, 32'd0);
        check("rst_valid", {31'd0, bus.valid_ID}, 32'd0);
        check("rst_insn", bus.i_data_read, C_NOP);
        check("rst_pc_id", bus.PC_ID, 32'd0);

        // Zero-wait streaming: first request, 2-cycle latency, full throughput
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("first_req", {31'd0, bus.i_req}, 32'd1);
        check("first_addr", bus.i_addr, C_RESET_PC);
        check("c1_valid", {31'd0, bus.valid_ID}, 32'd0);
        @(negedge clk);
        check("c2_addr", bus.i_addr, C_RESET_PC + 32'd4);
        check("c2_valid", {31'd0, bus.valid_ID}, 32'd0);
        @(negedge clk);
        check("c3_valid", {31'd0, bus.valid_ID}, 32'd1);
        check("c3_pc_id", bus.PC_ID, C_RESET_PC + 32'd4);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("throughput_valid", {31'd0, bus.valid_ID}, 32'd1);
        end

        // Stall after two fetched: outputs frozen, no requests
        bus.stall_ID = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_no_req", {31'd0, bus.i_req}, 32'd0);
            check("stall_valid", {31'd0, bus.valid_ID}, 32'd1);
            check("stall_insn", bus.i_data_read, mem_word(32'h0));
            check("stall_pc_id", bus.PC_ID, 32'h4);
        end
        @(posedge clk); #1;
        c0 = consumed;
        bus.stall_ID = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("stall_release_progress", {31'd0, (consumed - c0 >= 3)}, 32'd1);

        // Branch redirect with two reads outstanding
        lat_min = 4; lat_max = 4;
        do_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.pc_cmd_ex = 1'b1;
        bus.pc_in_EX  = 32'h0000_0103;
        @(negedge clk);
        check("redir_no_req", {31'd0, bus.i_req}, 32'd0);
        @(posedge clk); #1;
        clear_cmds();
        @(negedge clk);
        check("redir_valid_low", {31'd0, bus.valid_ID}, 32'd0);
        check("redir_addr", bus.i_addr, 32'h100);
        check("redir_credit_held", {31'd0, bus.i_req}, 32'd0);
        for (int k = 0; k < 20 && !bus.i_req; k++) @(negedge clk);
        check("redir_req", {31'd0, bus.i_req}, 32'd1);
        check("redir_req_addr", bus.i_addr, 32'h100);
        wait_valid("redir_wait_valid");
        check("redir_first_pc_id", bus.PC_ID, 32'h104);

        // Simultaneous branch and jump: branch wins
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (4) begin @(posedge clk); #1; end
        bus.pc_cmd_ex = 1'b1;
        bus.pc_in_EX  = 32'h200;
        bus.Pc_cmd_id = 1'b1;
        bus.pc_in_ID  = 32'h300;
        @(posedge clk); #1;
        clear_cmds();
        @(negedge clk);
        check("prio_addr", bus.i_addr, 32'h200);
        check("prio_valid_low", {31'd0, bus.valid_ID}, 32'd0);
        wait_valid("prio_wait_valid");
        check("prio_pc_id", bus.PC_ID, 32'h204);

        // Jump while stalled is ignored
        do_reset();
        repeat (4) begin @(posedge clk); #1; end
        bus.stall_ID = 1'b1;
        @(negedge clk);
        check("jstall_valid", {31'd0, bus.valid_ID}, 32'd1);
        d_hold = bus.i_data_read;
        p_hold = bus.PC_ID;
        @(posedge clk); #1;
        bus.Pc_cmd_id = 1'b1;
        bus.pc_in_ID  = 32'h400;
        @(posedge clk); #1;
        clear_cmds();
        @(negedge clk);
        check("jstall_still_valid", {31'd0, bus.valid_ID}, 32'd1);
        check("jstall_insn", bus.i_data_read, d_hold);
        check("jstall_pc_id", bus.PC_ID, p_hold);
        @(posedge clk); #1;
        bus.stall_ID = 1'b0;

        // Slow memory: ready low 3 of 5 cycles, latency 3
        ready_mode = 2; lat_min = 3; lat_max = 3;
        do_reset();
        c0 = consumed;
        repeat (60) @(posedge clk);
        #1;
        check("slow_progress", {31'd0, (consumed - c0 >= 5)}, 32'd1);

        // Randomised traffic with redirects, stalls and occasional resets
        ready_mode = 1; lat_min = 1; lat_max = 3;
        c0 = consumed;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            reset         = ($urandom_range(0, 499) == 0);
            bus.stall_ID  = ($urandom_range(0, 3) == 0);
            bus.pc_cmd_ex = ($urandom_range(0, 24) == 0);
            bus.pc_in_EX  = rand_target();
            bus.Pc_cmd_id = ($urandom_range(0, 19) == 0);
            bus.pc_in_ID  = rand_target();
        end
        @(posedge clk); #1;
        reset = 1'b0;
        clear_cmds();
        bus.stall_ID = 1'b0;
        check("random_progress", {31'd0, (consumed - c0 > 100)}, 32'd1);
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
